btn_event_ctrl: RTL and testbench
=================================

# btn_event_ctrl

Debounce scheduler and event generator for the game's push buttons. One shared debounce engine is time-multiplexed round-robin across `N_BTN` buttons. The engine keeps per-button shift history, stable level and hold counters. The block turns stable transitions into PRESS / RELEASE / LONG events and queues them in a small FIFO. Game logic drains the FIFO over a valid/ready handshake.

## Interface
- `N_BTN`, 4, number of buttons (1–8)
- `TICK_DIV`, 50000, clk cycles per sample tick; must be ≥ `N_BTN`+2
- `HIST`, 8, debounce history length in ticks
- `LONG_TICKS`, 64, stable-high ticks before a LONG event (≥ 2)
- `FIFO_DEPTH`, 4, event queue depth (power of 2)

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `btn_raw`  in  N_BTN  raw, asynchronous button inputs
- `btn_level`  out  N_BTN  debounced stable levels
- `evt_valid`  out  1  FIFO head valid
- `evt_ready`  in  1  consumer accepts head
- `evt_code`  out  2  01 PRESS, 10 RELEASE, 11 LONG (00 never emitted)
- `evt_id`  out  3  button index of head event
- `overflow`  out  1  sticky: an event was dropped
- `clr_overflow`  in  1  synchronous clear of `overflow`

## Operation
- `btn_raw` passes through a 2-flop synchronizer per bit, giving `sync`.
- The tick counter counts 0..`TICK_DIV`-1 and wraps. `tick` is asserted when it equals `TICK_DIV`-1.
- The scheduler FSM has two states:
  - IDLE: on `tick`, go to SCAN with index 0.
  - SCAN: visit button `idx` once per cycle. When `idx`=`N_BTN`-1, return to IDLE.
- Per visit of button i:
  - `h' = {hist[i][HIST-2:0], sync[i]}`; `hist[i] <= h'`.
  - If `h'` is all ones and `level[i]`=0: set `level` to 1, clear `hold`, clear `long_done`, push PRESS.
  - Else if `h'` is all zeros and `level[i]`=1: set `level` to 0, push RELEASE. RELEASE is emitted even after a LONG.
  - Else if `level[i]`=1 and `long_done`=0: increment `hold`. When `hold` reaches `LONG_TICKS`-1, push LONG and set `long_done`.
  - `hold` saturates and never wraps. Width is clog2(`LONG_TICKS`).
- At most one push per cycle.
- FIFO behaviour:
  - Push while full: the event is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both happen; count stays the same; no drop.
  - Pop occurs when `evt_valid` & `evt_ready`.
  - `evt_code` and `evt_id` are stable while `evt_valid`=1 and `evt_ready`=0.
- Overflow flag:
  - `clr_overflow` clears `overflow`.
  - If a drop occurs in the same cycle as `clr_overflow`, the set wins.
- Reset values:
  - All `hist` = 0, `level` = 0, `hold` = 0, `long_done` = 0.
  - Tick counter = 0, FSM = IDLE.
  - FIFO empty, so `evt_valid` = 0, `evt_code` = 0, `evt_id` = 0.
  - `overflow` = 0, `btn_level` = 0.
- Reset mid-scan aborts the scan with no partial events. After reset deasserts, the first tick occurs after `TICK_DIV` cycles.

## Timing
- `tick` at cycle t. Button i is visited at cycle t+1+i. Its `btn_level` and FIFO write register at the end of that cycle.
- `evt_valid` rises the cycle after the push if the FIFO was empty. There is no combinational path from push to `evt_valid`.
- Press latency: 2 synchronizer cycles plus `HIST` consecutive high samples. The transition is seen on the `HIST`-th tick at which `sync` is high.
- LONG is emitted `LONG_TICKS`-1 visits after the PRESS visit.
- Events are ordered by visit time. Within one scan, ascending `evt_id`.
- Throughput: one event popped per cycle while `evt_ready`=1.

## Structure
- Package `btn_evt_pkg` holds:
  - Event code constants `EVT_PRESS`, `EVT_RELEASE`, `EVT_LONG`.
  - The event struct / packed width: 2-bit code + 3-bit id.
  - FSM state encoding IDLE/SCAN.
- Sub-module `evt_fifo` is a synchronous FIFO with width 5 and depth `FIFO_DEPTH`. It uses pointers plus a count and exposes full/empty, push/pop, and a drop indication.
- The top level contains the synchronizer, tick counter, scheduler FSM, and per-button state arrays.

## Test plan
(`TICK_DIV`=8, `HIST`=4, `LONG_TICKS`=6, `N_BTN`=4.)
- **Reset:** assert `rst` mid-scan with events pending → next cycle `evt_valid`=0, `btn_level`=0000, `overflow`=0. No event appears until `btn_raw` is held for 4 ticks.
- **Clean press:** hold `btn_raw[2]`=1 → after 4 ticks `btn_level[2]`=1 and exactly one event {01,2}. Release for 4 ticks → {10,2}.
- **Bounce:** toggle `btn_raw[1]` every 2 ticks for 20 ticks → no events, `btn_level[1]` stays 0.
- **Long press:** hold `btn_raw[0]` for 15 ticks → {01,0}, then {11,0} exactly once 5 ticks later. Release → {10,0}.
- **Overflow:** press all four buttons together with `evt_ready`=0 → FIFO holds {01,0}..{01,3} in order. The next event (LONG of button 0) is dropped and `overflow`=1. Pulse `clr_overflow` → `overflow`=0.
- **Full with simultaneous pop:** FIFO full with `evt_ready`=1 in the same cycle as a push → no drop, `overflow` stays 0, pop order preserved.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// Shared types and constants for the button event controller.
//   EVT_PRESS / EVT_RELEASE / EVT_LONG : event codes carried in evt_code
//   evt_t                              : packed {code, id} queue entry
//   scan_state_e                       : debounce scheduler states
package btn_evt_pkg;

  localparam int EVT_CODE_W = 2;
  localparam int EVT_ID_W   = 3;
  localparam int EVT_W      = EVT_CODE_W + EVT_ID_W;

  localparam logic [EVT_CODE_W-1:0] EVT_NONE    = 2'b00;
  localparam logic [EVT_CODE_W-1:0] EVT_PRESS   = 2'b01;
  localparam logic [EVT_CODE_W-1:0] EVT_RELEASE = 2'b10;
  localparam logic [EVT_CODE_W-1:0] EVT_LONG    = 2'b11;

  typedef struct packed {
    logic [EVT_CODE_W-1:0] code;
    logic [EVT_ID_W-1:0]   id;
  } evt_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/evt_fifo.sv
// Synchronous event FIFO (read/write pointers plus occupancy count).
//   clk, rst       : clock, async active-high reset
//   push/push_data : write request and data; dropped when full without a pop
//   pop            : read request, ignored when empty
//   pop_data       : head entry, forced to zero while empty
//   full, empty    : occupancy flags
//   drop           : a push was discarded this cycle
module evt_fifo
  import btn_evt_pkg::*;
#(
  parameter int WIDTH = EVT_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A pop frees the slot in the same cycle, so a push into a full queue
  // that is also being drained is accepted rather than dropped.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// Button debounce scheduler and event generator.
// One debounce engine is shared round-robin across N_BTN buttons: each
// sample tick starts a scan that visits one button per cycle, shifts its
// history, and turns stable transitions into PRESS/RELEASE/LONG events
// queued in evt_fifo.
//   clk, rst      : clock, async active-high reset
//   btn_raw       : raw asynchronous button inputs
//   btn_level     : debounced stable levels
//   evt_valid     : queue head valid
//   evt_ready     : consumer accepts head
//   evt_code      : 01 PRESS, 10 RELEASE, 11 LONG
//   evt_id        : button index of head event
//   overflow      : sticky, an event was dropped
//   clr_overflow  : synchronous clear of overflow (a same-cycle drop wins)
//
// Scheduler states:
//   state   | meaning
//   ST_IDLE | waiting for the sample tick
//   ST_SCAN | visiting button idx, one per cycle, then back to idle
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int TICK_DIV   = 50000,
  parameter int HIST       = 8,
  parameter int LONG_TICKS = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_BTN-1:0]      btn_raw,
  output logic [N_BTN-1:0]      btn_level,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [EVT_CODE_W-1:0] evt_code,
  output logic [EVT_ID_W-1:0]   evt_id,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int IDX_W  = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int HOLD_W = $clog2(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;
  localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_TICKS - 1);

  // Input synchronizer.
  logic [N_BTN-1:0] sync_meta;
  logic [N_BTN-1:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
    end
  end

  // Sample tick divider.
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Scheduler FSM.
  scan_state_e      state_q;
  scan_state_e      state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             visit;

  assign visit = (state_q == ST_SCAN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        if (idx_q == IDX_W'(N_BTN - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Per-button debounce state.
  logic [HIST-1:0]   hist [N_BTN];
  logic [HOLD_W-1:0] hold [N_BTN];
  logic [N_BTN-1:0]  level_q;
  logic [N_BTN-1:0]  long_done;

  // Next values for the button currently being visited.
  logic [HIST-1:0]       hist_nx;
  logic                  level_nx;
  logic [HOLD_W-1:0]     hold_nx;
  logic                  long_nx;
  logic                  push;
  logic [EVT_CODE_W-1:0] push_code;

  assign hist_nx = {hist[idx_q][HIST-2:0], sync[idx_q]};

  always_comb begin
    level_nx  = level_q[idx_q];
    hold_nx   = hold[idx_q];
    long_nx   = long_done[idx_q];
    push      = 1'b0;
    push_code = EVT_NONE;
    if (visit) begin
      if ((&hist_nx) && !level_q[idx_q]) begin
        level_nx  = 1'b1;
        hold_nx   = '0;
        long_nx   = 1'b0;
        push      = 1'b1;
        push_code = EVT_PRESS;
      end else if (!(|hist_nx) && level_q[idx_q]) begin
        level_nx  = 1'b0;
        push      = 1'b1;
        push_code = EVT_RELEASE;
      end else if (level_q[idx_q] && !long_done[idx_q]) begin
        if (hold[idx_q] != HOLD_MAX) hold_nx = hold[idx_q] + HOLD_W'(1);
        if (hold_nx == HOLD_LONG) begin
          long_nx   = 1'b1;
          push      = 1'b1;
          push_code = EVT_LONG;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        hist[i] <= '0;
        hold[i] <= '0;
      end
      level_q   <= '0;
      long_done <= '0;
    end else if (visit) begin
      hist[idx_q]      <= hist_nx;
      hold[idx_q]      <= hold_nx;
      level_q[idx_q]   <= level_nx;
      long_done[idx_q] <= long_nx;
    end
  end

  assign btn_level = level_q;

  // Event queue.
  evt_t push_evt;
  evt_t head_evt;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_drop;
  logic pop;

  assign push_evt  = '{code: push_code, id: EVT_ID_W'(idx_q)};
  assign evt_valid = ~fifo_empty;
  assign pop       = evt_valid & evt_ready;
  assign evt_code  = head_evt.code;
  assign evt_id    = head_evt.id;

  evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_evt),
    .pop       (pop),
    .pop_data  (head_evt),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  // A drop can only come from a full queue.
  drop_needs_full: assert property (@(posedge clk) disable iff (rst) fifo_drop |-> fifo_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               overflow <= 1'b0;
    else if (fifo_drop)    overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
module tb_btn_event_ctrl;
  import btn_evt_pkg::*;

  localparam int TD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] btn_level;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [1:0] evt_code;
  logic [2:0] evt_id;
  logic       overflow;
  logic       clr_overflow = 1'b0;

  always #5 clk = ~clk;

  btn_event_ctrl #(
    .N_BTN      (4),
    .TICK_DIV   (TD),
    .HIST       (4),
    .LONG_TICKS (6),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_id       (evt_id),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  int         n_vec    = 0;
  int         n_err    = 0;
  int         n_popped = 0;
  logic [4:0] sb [$];
  logic [4:0] exp_e;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_evt(input logic [1:0] code, input int id);
    sb.push_back({code, 3'(id)});
  endtask

  task automatic ticks(input int n);
    repeat (n * TD) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      n_popped++;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL evt_unexpected: got code %b id %0d expected no event", evt_code, evt_id);
      end else begin
        exp_e = sb.pop_front();
        if ({evt_code, evt_id} !== exp_e) begin
          n_err++;
          $display("FAIL evt_order: got code %b id %0d expected code %b id %0d",
                   evt_code, evt_id, exp_e[4:3], exp_e[2:0]);
        end
      end
    end
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 8'(evt_valid), 8'd0);
    check("rst_code", 8'(evt_code), 8'd0);
    check("rst_id", 8'(evt_id), 8'd0);
    check("rst_overflow", 8'(overflow), 8'd0);
    check("rst_level", 8'(btn_level), 8'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Clean press / release of button 2
    btn_raw[2] = 1'b1;
    expect_evt(EVT_PRESS, 2);
    ticks(3);
    check("press_lvl_early", 8'(btn_level), 8'h0);
    ticks(1);
    check("press_lvl", 8'(btn_level), 8'h4);
    btn_raw[2] = 1'b0;
    expect_evt(EVT_RELEASE, 2);
    ticks(3);
    check("release_lvl_early", 8'(btn_level), 8'h4);
    ticks(1);
    check("release_lvl", 8'(btn_level), 8'h0);
    check("clean_pop_cnt", 8'(n_popped), 8'd2);

    // Bounce on button 1: no events, level stays low
    for (int i = 0; i < 10; i++) begin
      btn_raw[1] = (i % 2 == 0);
      ticks(2);
      check("bounce_lvl", 8'(btn_level[1]), 8'd0);
    end
    ticks(4);
    check("bounce_pop_cnt", 8'(n_popped), 8'd2);

    // Long press on button 0
    btn_raw[0] = 1'b1;
    expect_evt(EVT_PRESS, 0);
    expect_evt(EVT_LONG, 0);
    expect_evt(EVT_RELEASE, 0);
    ticks(4);
    check("long_press_lvl", 8'(btn_level), 8'h1);
    check("long_press_cnt", 8'(n_popped), 8'd3);
    ticks(4);
    check("long_not_yet", 8'(n_popped), 8'd3);
    ticks(1);
    check("long_at_5", 8'(n_popped), 8'd4);
    ticks(6);
    btn_raw[0] = 1'b0;
    ticks(3);
    check("long_rel_early", 8'(btn_level), 8'h1);
    ticks(1);
    check("long_rel_lvl", 8'(btn_level), 8'h0);
    check("long_rel_cnt", 8'(n_popped), 8'd5);

    // Overflow: four presses fill the queue, the LONGs are dropped
    evt_ready = 1'b0;
    btn_raw = 4'hF;
    for (int b = 0; b < 4; b++) expect_evt(EVT_PRESS, b);
    ticks(4);
    check("ovf_lvl", 8'(btn_level), 8'hF);
    check("ovf_valid", 8'(evt_valid), 8'd1);
    check("ovf_head_code", 8'(evt_code), 8'(EVT_PRESS));
    check("ovf_head_id", 8'(evt_id), 8'd0);
    ticks(4);
    check("ovf_before_long", 8'(overflow), 8'd0);
    ticks(1);
    check("ovf_set", 8'(overflow), 8'd1);
    check("ovf_head_stable", 8'({evt_code, evt_id}), 8'({EVT_PRESS, 3'd0}));
    clr_overflow = 1'b1;
    @(posedge clk); #1 clr_overflow = 1'b0;
    check("ovf_clr", 8'(overflow), 8'd0);
    repeat (7) @(posedge clk);
    #1;
    check("ovf_clr_hold", 8'(overflow), 8'd0);
    evt_ready = 1'b1;
    ticks(1);
    check("ovf_drain_cnt", 8'(n_popped), 8'd9);
    btn_raw = 4'h0;
    for (int b = 0; b < 4; b++) expect_evt(EVT_RELEASE, b);
    ticks(4);
    check("ovf_rel_lvl", 8'(btn_level), 8'h0);
    ticks(1);
    check("ovf_rel_cnt", 8'(n_popped), 8'd13);

    // Full queue with a pop in the same cycle as each LONG push
    evt_ready = 1'b0;
    btn_raw = 4'hF;
    for (int b = 0; b < 4; b++) expect_evt(EVT_PRESS, b);
    for (int b = 0; b < 4; b++) expect_evt(EVT_LONG, b);
    ticks(8);
    check("fp_full_valid", 8'(evt_valid), 8'd1);
    check("fp_ovf_pre", 8'(overflow), 8'd0);
    repeat (4) @(posedge clk);
    #1 evt_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("fp_no_drop", 8'(overflow), 8'd0);
    repeat (4) @(posedge clk);
    #1;
    check("fp_pop_cnt", 8'(n_popped), 8'd21);
    repeat (4) @(posedge clk);
    #1;
    btn_raw = 4'h0;
    for (int b = 0; b < 4; b++) expect_evt(EVT_RELEASE, b);
    ticks(4);
    check("fp_rel_lvl", 8'(btn_level), 8'h0);
    ticks(1);
    check("fp_rel_cnt", 8'(n_popped), 8'd25);

    // Reset mid-scan with events pending and overflow set
    evt_ready = 1'b0;
    btn_raw = 4'hF;
    ticks(9);
    check("mr_ovf_pre", 8'(overflow), 8'd1);
    check("mr_valid_pre", 8'(evt_valid), 8'd1);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mr_valid", 8'(evt_valid), 8'd0);
    check("mr_lvl", 8'(btn_level), 8'h0);
    check("mr_ovf", 8'(overflow), 8'd0);
    check("mr_code", 8'({evt_code, evt_id}), 8'd0);
    @(posedge clk); #1 rst = 1'b0;
    evt_ready = 1'b1;
    for (int b = 0; b < 4; b++) expect_evt(EVT_PRESS, b);
    repeat (4) @(posedge clk);
    #1;
    ticks(3);
    check("mr_lvl_early", 8'(btn_level), 8'h0);
    check("mr_no_evt", 8'(n_popped), 8'd25);
    ticks(1);
    check("mr_lvl_press", 8'(btn_level), 8'hF);
    btn_raw = 4'h0;
    for (int b = 0; b < 4; b++) expect_evt(EVT_RELEASE, b);
    ticks(4);
    check("mr_rel_lvl", 8'(btn_level), 8'h0);
    ticks(2);
    check("mr_pop_cnt", 8'(n_popped), 8'd33);
    check("sb_drained", 8'(sb.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
